// File: rtl/fetch_align_pkg.sv
// Shared definitions for the instruction fetch/alignment buffer.
// Holds the FSM state encodings, byte-geometry constants and the pad byte
// used for window positions past end-of-stream.
package fetch_align_pkg;

    localparam int unsigned MAX_INSTR_BYTES = 12;
    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned DEF_BUF_BYTES   = 16;
    localparam int unsigned LEN_W           = 4;
    localparam int unsigned WIN_W           = MAX_INSTR_BYTES * 8;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    // FSM state encodings
    localparam logic [2:0] ST_FILL   = 3'd0;
    localparam logic [2:0] ST_STREAM = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

endpackage

// File: rtl/fetch_align_shift.sv
// Combinational byte barrel shifter: moves the buffer down by shift_i bytes
// (0..12), filling vacated top bytes with the pad byte.
// Ports:
//   data_i  : BUF_BYTES*8 buffer contents, byte 0 in [7:0]
//   shift_i : byte shift amount
//   data_o  : shifted buffer
module fetch_shift
    import fetch_align_pkg::*;
#(
    parameter int unsigned BUF_BYTES = DEF_BUF_BYTES
) (
    input  logic [BUF_BYTES*8-1:0] data_i,
    input  logic [LEN_W-1:0]       shift_i,
    output logic [BUF_BYTES*8-1:0] data_o
);

    // Byte-wise shift with explicit pad fill above the shifted-out region
    always_comb begin
        data_o = '0;
        for (int unsigned b = 0; b < BUF_BYTES; b++) begin
            if (b + 32'(shift_i) < BUF_BYTES) begin
                data_o[b*8 +: 8] = data_i[(b + 32'(shift_i))*8 +: 8];
            end else begin
                data_o[b*8 +: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch/alignment buffer. Accepts a little-endian 32-bit word
// stream of program bytes and presents a 12-byte window at the current PC;
// the consumer retires instr_len bytes per accepted instruction.
// Optional feature macro: TINY86_FETCH_REDIRECT_EN (adds redirect_valid /
// redirect_pc ports that flush the buffer and restart at a new PC).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : word handshake; in_data byte 0 in [7:0]
//   in_last/in_nbytes     : final word marker and its valid byte count (1..4)
//   out_valid/out_ready   : window valid / retire strobe
//   raw_instr             : 12-byte window, byte at pc in [7:0]
//   instr_len             : bytes retired, sampled on retire
//   pc                    : address of raw_instr[7:0]
//   done                  : end-of-stream seen and buffer empty
//   fault                 : sticky illegal-retire flag
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_BYTES = DEF_BUF_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic [2:0]        in_nbytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIN_W-1:0]  raw_instr,
    input  logic [LEN_W-1:0]  instr_len,
    output logic [31:0]       pc,
    output logic              done,
    output logic              fault
`ifdef TINY86_FETCH_REDIRECT_EN
    ,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
`endif
);

    localparam int unsigned BUF_W = BUF_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(BUF_BYTES + 1);

    logic [BUF_W-1:0] buf_q,   buf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_q,    pc_d;
    logic             eos_q,   eos_d;
    logic [2:0]       state_q, state_d;

    logic             retire, len_bad, retire_ok, retire_bad, write;
    logic [2:0]       nbytes_w;
    logic [LEN_W-1:0] shift_amt;
    logic [CNT_W-1:0] base;
    logic [BUF_W-1:0] shifted;
    logic             redirect_hit;
    logic [31:0]      redirect_tgt;

    // Handshake outputs depend on registered state only
    assign in_ready  = (state_q != ST_FAULT) && !eos_q
                       && (count_q <= CNT_W'(BUF_BYTES - WORD_BYTES));
    assign out_valid = (state_q == ST_STREAM) || ((state_q == ST_DRAIN) && (count_q != '0));
    assign done      = (state_q == ST_DONE);
    assign fault     = (state_q == ST_FAULT);
    assign raw_instr = buf_q[WIN_W-1:0];
    assign pc        = pc_q;

    // Retire legality; an illegal retire also suppresses any same-cycle write
    assign retire     = out_valid && out_ready;
    assign len_bad    = (instr_len == '0) || (instr_len > LEN_W'(MAX_INSTR_BYTES))
                        || (CNT_W'(instr_len) > count_q);
    assign retire_ok  = retire && !len_bad;
    assign retire_bad = retire && len_bad;
    assign write      = in_valid && in_ready && !retire_bad;

    // Non-final words always carry four bytes; out-of-range counts on a final word also
    assign nbytes_w   = (in_last && (in_nbytes >= 3'd1) && (in_nbytes <= 3'd4)) ? in_nbytes : 3'd4;
    assign shift_amt  = retire_ok ? instr_len : '0;
    assign base       = count_q - CNT_W'(shift_amt);

`ifdef TINY86_FETCH_REDIRECT_EN
    assign redirect_hit = redirect_valid && (state_q != ST_FAULT);
    assign redirect_tgt = redirect_pc;
`else
    assign redirect_hit = 1'b0;
    assign redirect_tgt = RESET_PC;
`endif

    fetch_shift #(
        .BUF_BYTES (BUF_BYTES)
    ) u_shift (
        .data_i  (buf_q),
        .shift_i (shift_amt),
        .data_o  (shifted)
    );

    // Next-state: shift, append, counters and FSM
    always_comb begin
        buf_d   = shifted;
        count_d = count_q;
        pc_d    = pc_q;
        eos_d   = eos_q;
        state_d = state_q;

        if (retire_ok) begin
            pc_d = pc_q + 32'(instr_len);
        end
        count_d = base + (write ? CNT_W'(nbytes_w) : '0);
        eos_d   = eos_q | (write & in_last);

        // Append lands right after the surviving bytes; bytes above stay pad
        if (write) begin
            for (int unsigned b = 0; b < BUF_BYTES; b++) begin
                for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                    if ((k < 32'(nbytes_w)) && (b == 32'(base) + k)) begin
                        buf_d[b*8 +: 8] = in_data[k*8 +: 8];
                    end
                end
            end
        end

        case (state_q)
            ST_FILL, ST_STREAM: begin
                if (retire_bad) begin
                    state_d = ST_FAULT;
                end else if (eos_d && (count_d == '0)) begin
                    state_d = ST_DONE;
                end else if (eos_d && (count_d < CNT_W'(MAX_INSTR_BYTES))) begin
                    state_d = ST_DRAIN;
                end else if (count_d >= CNT_W'(MAX_INSTR_BYTES)) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (retire_bad) begin
                    state_d = ST_FAULT;
                end else if (count_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase

        // Redirect wins over any same-cycle write or retire
        if (redirect_hit) begin
            buf_d   = '0;
            count_d = '0;
            pc_d    = redirect_tgt;
            eos_d   = 1'b0;
            state_d = ST_FILL;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            eos_q   <= 1'b0;
            state_q <= ST_FILL;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            eos_q   <= eos_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: directed scenarios plus randomized
// streams, compared every cycle against a byte-queue reference model.
module tb_fetch_align;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, done, fault;
    logic [31:0] in_data, pc;
    logic [2:0]  in_nbytes;
    logic [95:0] raw_instr;
    logic [3:0]  instr_len;
`ifdef TINY86_FETCH_REDIRECT_EN
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
`endif

    fetch_align #(.RESET_PC(RST_PC), .BUF_BYTES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .raw_instr (raw_instr),
        .instr_len (instr_len),
        .pc        (pc),
        .done      (done),
        .fault     (fault)
`ifdef TINY86_FETCH_REDIRECT_EN
        ,
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: buffered bytes as a queue, plus PC / eos / fault flags
    logic [7:0]  mq[$];
    logic [7:0]  prog[$];
    logic [31:0] m_pc;
    bit          m_eos, m_fault;
    int          wr_pos;
    int          npass = 0, nfail = 0, ntotal = 0;

    function automatic bit m_in_ready();
        return !m_fault && !m_eos && (mq.size() <= 12);
    endfunction

    function automatic bit m_done();
        return !m_fault && m_eos && (mq.size() == 0);
    endfunction

    function automatic bit m_out_valid();
        return !m_fault && (mq.size() > 0) && ((mq.size() >= 12) || m_eos);
    endfunction

    function automatic logic [95:0] m_raw();
        logic [95:0] r = '0;
        for (int i = 0; i < 12; i++) if (i < mq.size()) r[i*8 +: 8] = mq[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  96'(in_ready),  96'(m_in_ready()));
        chk({tag, ".out_valid"}, 96'(out_valid), 96'(m_out_valid()));
        chk({tag, ".raw_instr"}, raw_instr,      m_raw());
        chk({tag, ".pc"},        96'(pc),        96'(m_pc));
        chk({tag, ".done"},      96'(done),      96'(m_done()));
        chk({tag, ".fault"},     96'(fault),     96'(m_fault));
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = RST_PC;
        m_eos   = 1'b0;
        m_fault = 1'b0;
        wr_pos  = 0;
    endtask

    // Apply the current inputs to the model (called just before the active edge)
    task automatic model_step();
        bit rv, wv;
        int n;
`ifdef TINY86_FETCH_REDIRECT_EN
        if (redirect_valid && !m_fault) begin
            mq.delete();
            m_pc  = redirect_pc;
            m_eos = 1'b0;
            return;
        end
`endif
        rv = m_out_valid() && out_ready;
        wv = m_in_ready() && in_valid;
        if (rv && (instr_len == 0 || instr_len > 12 || int'(instr_len) > mq.size())) begin
            m_fault = 1'b1;
            return;
        end
        if (rv) begin
            repeat (int'(instr_len)) void'(mq.pop_front());
            m_pc = m_pc + 32'(instr_len);
        end
        if (wv) begin
            n = in_last ? int'(in_nbytes) : 4;
            for (int k = 0; k < n; k++) mq.push_back(in_data[k*8 +: 8]);
            if (in_last) m_eos = 1'b1;
            wr_pos += 4;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Present the next program word; bytes past the program end are garbage
    task automatic drive_word(input bit want);
        int rem = prog.size() - wr_pos;
        in_data   = $urandom;
        in_nbytes = 3'($urandom);
        in_last   = 1'b0;
        in_valid  = 1'b0;
        if (want && rem > 0) begin
            in_valid = 1'b1;
            in_last  = (rem <= 4);
            if (rem <= 4) in_nbytes = 3'(rem);
            for (int k = 0; k < 4; k++) if (k < rem) in_data[k*8 +: 8] = prog[wr_pos + k];
        end
    endtask

    task automatic rand_retire(input int pct);
        int lim = (mq.size() < 12) ? mq.size() : 12;
        out_ready = ($urandom_range(99) < pct);
        instr_len = 4'($urandom);
        if (out_ready && lim > 0) instr_len = 4'($urandom_range(lim, 1));
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = 3'd4;
        in_data   = '0;
        out_ready = 1'b0;
        instr_len = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic make_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
    endtask

    task automatic run_random(input string tag, input int budget);
        int cyc = 0;
        while (!(m_done() || m_fault) && cyc < budget) begin
            drive_word($urandom_range(99) < 70);
            rand_retire(60);
            tick(tag);
            cyc++;
        end
        chk({tag, ".finished"}, 96'(done), 96'(1));
    endtask

    task automatic fill_until_valid(input string tag);
        int cyc = 0;
        out_ready = 1'b0;
        while (!m_out_valid() && cyc < 20) begin
            drive_word(1'b1);
            tick(tag);
            cyc++;
        end
        chk({tag, ".filled"}, 96'(out_valid), 96'(1));
    endtask

    task automatic run_fault(input string tag, input int plen, input logic [3:0] bad_len);
        do_reset();
        make_prog(plen);
        fill_until_valid(tag);
        drive_word(1'b1);
        out_ready = 1'b1;
        instr_len = bad_len;
        tick(tag);
        chk({tag, ".fault"},    96'(fault),    96'(1));
        chk({tag, ".pc_held"},  96'(pc),       96'(RST_PC));
        chk({tag, ".in_ready"}, 96'(in_ready), 96'(0));
        idle();
        tick({tag, ".hold"});
    endtask

    initial begin
        // Directed: sequential bytes 00.. fill with no retire
        do_reset();
        prog.delete();
        for (int i = 0; i < 24; i++) prog.push_back(8'(i));
        out_ready = 1'b0;
        instr_len = 4'd0;
        for (int c = 0; c < 5; c++) begin
            drive_word(1'b1);
            tick("fill");
        end
        chk("fill.byte0",  96'(raw_instr[7:0]),   96'(8'h00));
        chk("fill.byte11", 96'(raw_instr[95:88]), 96'(8'h0B));
        chk("fill.full",   96'(in_ready),          96'(0));
        chk("fill.pc",     96'(pc),                96'(RST_PC));

        // Retire 3, then 1, then 3 with a concurrent write
        in_valid = 1'b0; out_ready = 1'b1; instr_len = 4'd3;
        tick("ret3");
        chk("ret3.byte0", 96'(raw_instr[7:0]), 96'(8'h03));
        instr_len = 4'd1;
        tick("ret1");
        drive_word(1'b1); out_ready = 1'b1; instr_len = 4'd3;
        tick("ret3w");
        chk("ret3w.pc", 96'(pc), 96'(RST_PC + 32'd7));
        run_random("fill_tail", 400);

        // Directed: five-byte program drains with zero padding
        do_reset();
        prog = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        fill_until_valid("five");
        idle(); out_ready = 1'b1; instr_len = 4'd2;
        tick("five.r2");
        chk("five.pad", raw_instr[95:24], 72'h0);
        instr_len = 4'd3;
        tick("five.r3");
        chk("five.done",  96'(done),      96'(1));
        chk("five.oval",  96'(out_valid), 96'(0));
        idle();
        tick("five.hold");

        // Illegal retires
        run_fault("fault_len0",  16, 4'd0);
        run_fault("fault_len13", 16, 4'd13);
        run_fault("fault_over",  4,  4'd5);

        // Asynchronous reset between edges mid-stream
        do_reset();
        make_prog(40);
        fill_until_valid("arst");
        idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("arst.now");
        chk("arst.raw", raw_instr, 96'h0);
        @(negedge clk);
        rst = 1'b0;
        make_prog(30);
        run_random("arst.refill", 600);

`ifdef TINY86_FETCH_REDIRECT_EN
        // Redirect with a full buffer and a same-cycle retire
        do_reset();
        make_prog(32);
        for (int c = 0; c < 5; c++) begin
            drive_word(1'b1);
            tick("redir.fill");
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        out_ready = 1'b1; instr_len = 4'd3; in_valid = 1'b0;
        tick("redir");
        redirect_valid = 1'b0;
        chk("redir.pc",   96'(pc),        96'(32'h100));
        chk("redir.oval", 96'(out_valid), 96'(0));
        chk("redir.rdy",  96'(in_ready),  96'(1));
        make_prog(20);
        wr_pos = 0;
        run_random("redir.after", 600);
`endif

        // Randomized programs of assorted lengths
        for (int r = 0; r < 8; r++) begin
            do_reset();
            make_prog($urandom_range(48, 1));
            run_random($sformatf("rand%0d", r), 600);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
